// File: rtl/pwm_multi_gen_if.sv
// Control/output bundle for pwm_multi_gen.
// The pol field exists only when PWM_POLARITY_EN is defined.
interface pwm_multi_gen_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
);
  logic                         en;
  logic [WIDTH-1:0]             period;
  logic [CHANNELS*WIDTH-1:0]    duty;
  logic                         center;
  logic                         load;
`ifdef PWM_POLARITY_EN
  logic [CHANNELS-1:0]          pol;
`endif
  logic [CHANNELS-1:0]          pwm_out;
  logic                         period_end;

`ifdef PWM_POLARITY_EN
  modport master (
    output en, period, duty, center, load, pol,
    input  pwm_out, period_end
  );
  modport slave (
    input  en, period, duty, center, load, pol,
    output pwm_out, period_end
  );
`else
  modport master (
    output en, period, duty, center, load,
    input  pwm_out, period_end
  );
  modport slave (
    input  en, period, duty, center, load,
    output pwm_out, period_end
  );
`endif
endinterface

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM: shared edge/center-aligned counter, double-buffered period/duty/mode.
// Optional per-channel output polarity when PWM_POLARITY_EN is defined.
module pwm_multi_gen #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
) (
  input logic            clk,
  input logic            rst_n,
  pwm_multi_gen_if.slave bus
);

  typedef enum logic {DirUp, DirDown} dir_e;

  logic [WIDTH-1:0]                 cnt_q, cnt_d;
  dir_e                             dir_q, dir_d;
  logic [WIDTH-1:0]                 period_s_q, period_s_d;
  logic [CHANNELS-1:0][WIDTH-1:0]   duty_s_q, duty_s_d;
  logic                             center_s_q, center_s_d;
  logic [CHANNELS-1:0]              pol_s_q, pol_s_d;
  logic                             pend_q, pend_d;
  logic                             start_q, start_d;
  logic [CHANNELS-1:0]              pwm_q, pwm_d;
  logic                             period_end_q, period_end_d;

  logic [CHANNELS-1:0]              pol_in;
  logic                             center_eff;
  logic                             boundary;
  logic                             take_shadow;

`ifdef PWM_POLARITY_EN
  assign pol_in = bus.pol;
`else
  assign pol_in = '0;
`endif

  // period_s==0 in center mode degenerates to a 1-cycle edge-aligned period.
  assign center_eff = center_s_q && (period_s_q != '0);

  always_comb begin
    if (center_eff) begin
      // With period_s==1 the down-count phase is empty, so the top is also the end.
      boundary = (cnt_q == WIDTH'(1)) && ((dir_q == DirDown) || (period_s_q == WIDTH'(1)));
    end else begin
      boundary = (cnt_q == period_s_q);
    end
  end

  always_comb begin
    cnt_d        = cnt_q;
    dir_d        = dir_q;
    pend_d       = pend_q;
    start_d      = 1'b0;
    period_end_d = 1'b0;
    pwm_d        = pol_s_q;
    take_shadow  = 1'b0;

    if (!bus.en) begin
      cnt_d = '0;
      dir_d = DirUp;
      if (bus.load) begin
        take_shadow = 1'b1;
        pend_d      = 1'b0;
      end
    end else begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        pwm_d[k] = (cnt_q < duty_s_q[k]) ^ pol_s_q[k];
      end
      // Pulse is delayed one cycle so it lines up with the first output of the new period.
      start_d      = boundary;
      period_end_d = start_q;
      if (bus.load) begin
        pend_d = 1'b1;
      end
      if (boundary) begin
        cnt_d = '0;
        dir_d = DirUp;
        if (bus.load || pend_q) begin
          take_shadow = 1'b1;
          pend_d      = 1'b0;
        end
      end else if (!center_eff) begin
        cnt_d = cnt_q + WIDTH'(1);
      end else if (dir_q == DirUp) begin
        if (cnt_q == period_s_q) begin
          cnt_d = cnt_q - WIDTH'(1);
          dir_d = DirDown;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end
  end

  always_comb begin
    period_s_d = period_s_q;
    duty_s_d   = duty_s_q;
    center_s_d = center_s_q;
    pol_s_d    = pol_s_q;
    if (take_shadow) begin
      period_s_d = bus.period;
      center_s_d = bus.center;
      pol_s_d    = pol_in;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        duty_s_d[k] = bus.duty[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      dir_q        <= DirUp;
      period_s_q   <= '0;
      duty_s_q     <= '0;
      center_s_q   <= 1'b0;
      pol_s_q      <= '0;
      pend_q       <= 1'b0;
      start_q      <= 1'b0;
      pwm_q        <= '0;
      period_end_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      period_s_q   <= period_s_d;
      duty_s_q     <= duty_s_d;
      center_s_q   <= center_s_d;
      pol_s_q      <= pol_s_d;
      pend_q       <= pend_d;
      start_q      <= start_d;
      pwm_q        <= pwm_d;
      period_end_q <= period_end_d;
    end
  end

  assign bus.pwm_out    = pwm_q;
  assign bus.period_end = period_end_q;

endmodule
